typec_tx_sched: RTL and testbench

Transmit scheduler for the Type-C link packet transmitter (`typec_tx`). It accepts level requests from up to seven packet sources and arbitrates between them. It drives the transmitter's `btype` and `fs` inputs and completes the `fs`/`fd` handshake. It returns a one-cycle grant to the source whose packet has been sent. It sits between the link-layer state machines (handshake responder, data/status producers) and `typec_tx`, so that no two sources drive the transmitter at once.

---
 rtl/typec_pkg.sv | 47 ++++
 rtl/typec_tx_sched_if.sv | 23 ++
 rtl/rr_arb4.sv | 37 +++
 rtl/typec_tx_sched.sv | 137 +++++++++++++
 tb/tb_typec_tx_sched.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/typec_pkg.sv
// Shared Type-C link definitions: packet btype codes, request bit indices and
// the transmit scheduler state encoding.
package typec_pkg;

    localparam int NUM_REQ = 7;

    localparam int REQ_ACK   = 0;
    localparam int REQ_NAK   = 1;
    localparam int REQ_STALL = 2;
    localparam int REQ_DLINK = 3;
    localparam int REQ_DTYPE = 4;
    localparam int REQ_DTEMP = 5;
    localparam int REQ_DATA0 = 6;

    localparam logic [3:0] BAG_NONE  = 4'b0000;
    localparam logic [3:0] BAG_ACK   = 4'b0001;
    localparam logic [3:0] BAG_NAK   = 4'b0010;
    localparam logic [3:0] BAG_STALL = 4'b0011;
    localparam logic [3:0] BAG_DLINK = 4'b1000;
    localparam logic [3:0] BAG_DTYPE = 4'b1001;
    localparam logic [3:0] BAG_DTEMP = 4'b1010;
    localparam logic [3:0] BAG_DATA0 = 4'b1101;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_DONE,
        ST_RELEASE,
        ST_GAP,
        ST_ABORT
    } txs_state_e;

    function automatic logic [3:0] btype_of(input logic [2:0] idx);
        case (idx)
            3'(REQ_ACK):   return BAG_ACK;
            3'(REQ_NAK):   return BAG_NAK;
            3'(REQ_STALL): return BAG_STALL;
            3'(REQ_DLINK): return BAG_DLINK;
            3'(REQ_DTYPE): return BAG_DTYPE;
            3'(REQ_DTEMP): return BAG_DTEMP;
            3'(REQ_DATA0): return BAG_DATA0;
            default:       return BAG_NONE;
        endcase
    endfunction

endpackage

// File: rtl/typec_tx_sched_if.sv
// Request/grant and typec_tx handshake bundle around the transmit scheduler.
// master = packet sources plus typec_tx; slave = the scheduler itself.
interface typec_tx_sched_if;
    import typec_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
    logic               busy;
    logic               tx_fs;
    logic               tx_fd;
    logic [3:0]         btype;
    logic               err;

    modport master (
        output req, tx_fd,
        input  gnt, busy, tx_fs, btype, err
    );

    modport slave (
        input  req, tx_fd,
        output gnt, busy, tx_fs, btype, err
    );
endinterface

// File: rtl/rr_arb4.sv
// 4-way round-robin arbiter: combinational pick starting at the pointer;
// advance moves the pointer to the slot above the current winner.
module rr_arb4 (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       advance,
    output logic [1:0] grant_idx,
    output logic       grant_valid
);
    logic [1:0] ptr;
    logic [1:0] cand;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = ptr;
        cand        = ptr;
        for (int i = 0; i < 4; i++) begin
            cand = ptr + 2'(i);
            if (!grant_valid && req[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Slot 0 is the first data source, so reset leaves it with top priority.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= 2'd0;
        end else if (advance && grant_valid) begin
            ptr <= grant_idx + 2'd1;
        end
    end
endmodule

// File: rtl/typec_tx_sched.sv
// Transmit scheduler for typec_tx: arbitrates seven packet sources and runs the tx_fs/tx_fd handshake.
// Define TXS_TIMEOUT_EN to abort a SEND that sees no tx_fd within TIMEOUT cycles.
module typec_tx_sched
    import typec_pkg::*;
#(
    parameter int GAP     = 4,
    parameter int TIMEOUT = 4096
) (
    input  logic            clk,
    input  logic            rst,
    typec_tx_sched_if.slave bus
);
    localparam logic [7:0] GAP_LOAD = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

    if (GAP < 0 || GAP > 255) begin : g_bad_gap
        $error("typec_tx_sched: GAP must be 0..255");
    end
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("typec_tx_sched: TIMEOUT must be at least 2");
    end

    txs_state_e state, state_nxt;
    logic [2:0] idx;
    logic [3:0] btype_q;
    logic [7:0] gap_cnt;
    logic [1:0] rr_idx;
    logic       rr_valid;
    logic       rr_advance;
    logic       win_valid;
    logic [2:0] win_idx;
    logic       fs_timeout;

    rr_arb4 u_rr (
        .clk         (clk),
        .rst         (rst),
        .req         (bus.req[REQ_DATA0:REQ_DLINK]),
        .advance     (rr_advance),
        .grant_idx   (rr_idx),
        .grant_valid (rr_valid)
    );

    // Handshake class is fixed priority and always beats the round-robin data class.
    always_comb begin
        win_valid  = 1'b1;
        win_idx    = 3'(REQ_ACK);
        rr_advance = 1'b0;
        if (bus.req[REQ_ACK]) begin
            win_idx = 3'(REQ_ACK);
        end else if (bus.req[REQ_NAK]) begin
            win_idx = 3'(REQ_NAK);
        end else if (bus.req[REQ_STALL]) begin
            win_idx = 3'(REQ_STALL);
        end else if (rr_valid) begin
            win_idx    = 3'(REQ_DLINK) + {1'b0, rr_idx};
            rr_advance = (state == ST_IDLE);
        end else begin
            win_valid = 1'b0;
        end
    end

`ifdef TXS_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT);
    logic [TW-1:0] to_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt <= '0;
        end else if (state == ST_SEND) begin
            to_cnt <= to_cnt + TW'(1);
        end else begin
            to_cnt <= '0;
        end
    end

    assign fs_timeout = (state == ST_SEND) && (to_cnt == TW'(TIMEOUT - 1));
    assign bus.err    = (state == ST_ABORT);
`else
    assign fs_timeout = 1'b0;
    assign bus.err    = 1'b0;
`endif

    // Asynchronous reset drops tx_fs the moment rst rises, abandoning any packet in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        bus.busy  = (state != ST_IDLE);
        bus.tx_fs = 1'b0;
        bus.gnt   = '0;
        bus.btype = btype_q;
        case (state)
            ST_IDLE:    if (win_valid) state_nxt = ST_LOAD;
            ST_LOAD:    state_nxt = ST_SEND;
            ST_SEND: begin
                bus.tx_fs = 1'b1;
                if (bus.tx_fd) begin
                    state_nxt = ST_DONE;
                end else if (fs_timeout) begin
                    state_nxt = ST_ABORT;
                end
            end
            ST_DONE: begin
                bus.gnt   = NUM_REQ'(1) << idx;
                state_nxt = ST_RELEASE;
            end
            ST_ABORT:   state_nxt = ST_RELEASE;
            ST_RELEASE: if (!bus.tx_fd) state_nxt = (GAP == 0) ? ST_IDLE : ST_GAP;
            ST_GAP:     if (gap_cnt == 8'd0) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // The winner is latched in IDLE so a request dropping mid-packet cannot cancel it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx     <= '0;
            btype_q <= BAG_NONE;
            gap_cnt <= '0;
        end else begin
            if (state == ST_IDLE && win_valid) begin
                idx     <= win_idx;
                btype_q <= btype_of(win_idx);
            end
            if (state == ST_RELEASE) begin
                gap_cnt <= GAP_LOAD;
            end else if (state == ST_GAP && gap_cnt != 8'd0) begin
                gap_cnt <= gap_cnt - 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_typec_tx_sched.sv
// Scoreboard bench for typec_tx_sched: directed requests, a typec_tx fs/fd responder,
// and a monitor that checks every grant pulse against queued expectations.
module tb_typec_tx_sched;
    import typec_pkg::*;

    localparam int GAP = 4;
`ifdef TXS_TIMEOUT_EN
    localparam int TIMEOUT = 16;
`else
    localparam int TIMEOUT = 4096;
`endif

    typedef struct {
        string      name;
        logic [6:0] gnt;
        logic [3:0] btype;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    typec_tx_sched_if bus ();

    typec_tx_sched #(.GAP(GAP), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb[$];
    bit   fd_enable = 1'b1;
    bit   err_allowed = 1'b0;
    int   fd_rise_cyc = -100;
    int   fd_fall_cyc = -100;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name, input string why);
        n_checks++;
        n_fail++;
        $display("FAIL %s: %s (cycle %0d)", name, why, cyc);
    endtask

    task automatic expect_pkt(input string name, input int bit_idx, input logic [3:0] bt);
        exp_t e;
        e.name          = name;
        e.gnt           = '0;
        e.gnt[bit_idx]  = 1'b1;
        e.btype         = bt;
        sb.push_back(e);
    endtask

    // typec_tx model: raise tx_fd after 10 cycles of tx_fs, drop it on the second cycle tx_fs is low.
    initial begin
        int hi_cnt;
        int lo_cnt;
        hi_cnt = 0;
        lo_cnt = 0;
        bus.tx_fd = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.tx_fs) begin
                lo_cnt = 0;
                hi_cnt++;
                if (fd_enable && !bus.tx_fd && hi_cnt >= 10) begin
                    bus.tx_fd   = 1'b1;
                    fd_rise_cyc = cyc;
                end
            end else begin
                hi_cnt = 0;
                lo_cnt++;
                if (bus.tx_fd && lo_cnt >= 2) begin
                    bus.tx_fd   = 1'b0;
                    fd_fall_cyc = cyc;
                end
            end
        end
    end

    // Sources drop their request on the grant pulse.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.gnt != '0) bus.req = bus.req & ~bus.gnt;
        end
    end

    // Monitor: every grant pulse pops one expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.gnt !== '0) begin
                if (sb.size() == 0) begin
                    fail_now("unexpected_gnt", $sformatf("got gnt=%b with nothing expected", bus.gnt));
                end else begin
                    e = sb.pop_front();
                    check({e.name, "_gnt"}, 32'(bus.gnt), 32'(e.gnt));
                    check({e.name, "_btype"}, 32'(bus.btype), 32'(e.btype));
                    check({e.name, "_fs_low_at_gnt"}, 32'(bus.tx_fs), 32'd0);
                    check({e.name, "_fd_to_gnt"}, 32'(cyc - fd_rise_cyc), 32'd1);
                end
            end
            if (bus.err !== 1'b0 && !err_allowed)
                fail_now("unexpected_err", "err pulsed while no timeout was expected");
        end
    end

    task automatic wait_fs_rise(input string name, output int at);
        int n;
        n  = 0;
        at = -1;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.tx_fs && n < 300);
        if (bus.tx_fs) at = cyc;
        else fail_now(name, "tx_fs never rose");
    endtask

    task automatic wait_fd_fall(input string name, output int at);
        int n;
        int prev;
        n    = 0;
        prev = fd_fall_cyc;
        at   = -1;
        do begin
            @(negedge clk);
            n++;
        end while (fd_fall_cyc == prev && n < 300);
        if (fd_fall_cyc != prev) at = fd_fall_cyc;
        else fail_now(name, "tx_fd never fell");
    endtask

    task automatic wait_gnt_bit(input string name, input int b);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.gnt[b] && n < 300);
        if (!bus.gnt[b]) fail_now(name, "grant never seen");
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((sb.size() != 0 || bus.busy) && n < 1000);
        check({name, "_pending_left"}, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int t_req;
        int t_at;
        int t_fall;
        logic [3:0] exp_bt [3];
        exp_bt[0] = BAG_NAK;
        exp_bt[1] = BAG_STALL;
        exp_bt[2] = BAG_DATA0;

        bus.req = '0;
        rst     = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_gnt",   32'(bus.gnt),   32'd0);
        check("reset_busy",  32'(bus.busy),  32'd0);
        check("reset_tx_fs", 32'(bus.tx_fs), 32'd0);
        check("reset_btype", 32'(bus.btype), 32'd0);
        check("reset_err",   32'(bus.err),   32'd0);
        rst = 1'b0;

        // Single ACK request.
        @(negedge clk);
        bus.req[REQ_ACK] = 1'b1;
        t_req = cyc;
        expect_pkt("single_ack", REQ_ACK, BAG_ACK);
        wait_fs_rise("single_fs", t_at);
        check("single_req_to_fs", 32'(t_at - t_req), 32'd2);
        check("single_btype_in_send", 32'(bus.btype), 32'(BAG_ACK));
        wait_drain("single");

        // Fixed priority and data after handshake, with minimum inter-packet spacing.
        @(negedge clk);
        bus.req[REQ_NAK]   = 1'b1;
        bus.req[REQ_STALL] = 1'b1;
        bus.req[REQ_DATA0] = 1'b1;
        expect_pkt("prio_nak",   REQ_NAK,   BAG_NAK);
        expect_pkt("prio_stall", REQ_STALL, BAG_STALL);
        expect_pkt("prio_data0", REQ_DATA0, BAG_DATA0);
        wait_fs_rise("prio_fs0", t_at);
        check("prio_btype0", 32'(bus.btype), 32'(exp_bt[0]));
        for (int k = 1; k < 3; k++) begin
            wait_fd_fall("prio_fd_fall", t_fall);
            wait_fs_rise("prio_fs", t_at);
            check($sformatf("prio_spacing%0d", k), 32'(t_at - t_fall), 32'(GAP + 3));
            check($sformatf("prio_btype%0d", k), 32'(bus.btype), 32'(exp_bt[k]));
        end
        wait_drain("prio");

        // Round-robin over all four data sources; DLINK re-requests right after its grant.
        @(negedge clk);
        bus.req[REQ_DATA0:REQ_DLINK] = 4'hF;
        expect_pkt("rr_dlink",  REQ_DLINK, BAG_DLINK);
        expect_pkt("rr_dtype",  REQ_DTYPE, BAG_DTYPE);
        expect_pkt("rr_dtemp",  REQ_DTEMP, BAG_DTEMP);
        expect_pkt("rr_data0",  REQ_DATA0, BAG_DATA0);
        expect_pkt("rr_dlink2", REQ_DLINK, BAG_DLINK);
        wait_gnt_bit("rr_first_dlink", REQ_DLINK);
        @(negedge clk);
        bus.req[REQ_DLINK] = 1'b1;
        wait_drain("rr");

        // ACK raised while DATA0 is in SEND waits for DATA0 to finish.
        @(negedge clk);
        bus.req[REQ_DATA0] = 1'b1;
        expect_pkt("preempt_data0", REQ_DATA0, BAG_DATA0);
        expect_pkt("preempt_ack",   REQ_ACK,   BAG_ACK);
        wait_fs_rise("preempt_fs", t_at);
        @(negedge clk);
        bus.req[REQ_ACK] = 1'b1;
        wait_drain("preempt");

        // A request dropped mid-packet is still granted.
        @(negedge clk);
        bus.req[REQ_DTYPE] = 1'b1;
        expect_pkt("dropped_dtype", REQ_DTYPE, BAG_DTYPE);
        wait_fs_rise("dropped_fs", t_at);
        @(negedge clk);
        bus.req[REQ_DTYPE] = 1'b0;
        wait_drain("dropped");

        // Reset in the middle of SEND, then the held request is served again.
        @(negedge clk);
        bus.req[REQ_DTEMP] = 1'b1;
        wait_fs_rise("rst_fs", t_at);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_tx_fs", 32'(bus.tx_fs), 32'd0);
        check("midrst_busy",  32'(bus.busy),  32'd0);
        check("midrst_gnt",   32'(bus.gnt),   32'd0);
        check("midrst_btype", 32'(bus.btype), 32'd0);
        repeat (2) @(negedge clk);
        rst   = 1'b0;
        t_req = cyc;
        expect_pkt("rst_retry_dtemp", REQ_DTEMP, BAG_DTEMP);
        wait_fs_rise("rst_retry_fs", t_at);
        check("rst_retry_latency", 32'(t_at - t_req), 32'd2);
        check("rst_retry_btype", 32'(bus.btype), 32'(BAG_DTEMP));
        wait_drain("rst_retry");

`ifdef TXS_TIMEOUT_EN
        // tx_fd withheld: abort after TIMEOUT cycles of SEND, then retry after the gap.
        err_allowed = 1'b1;
        fd_enable   = 1'b0;
        @(negedge clk);
        bus.req[REQ_ACK] = 1'b1;
        wait_fs_rise("to_fs", t_req);
        begin
            int n;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!bus.err && n < 300);
            if (!bus.err) fail_now("to_err", "err never pulsed");
        end
        t_fall = cyc;
        check("to_send_to_err", 32'(t_fall - t_req), 32'(TIMEOUT));
        check("to_fs_low_at_err", 32'(bus.tx_fs), 32'd0);
        check("to_no_gnt", 32'(bus.gnt), 32'd0);
        fd_enable = 1'b1;
        expect_pkt("to_retry_ack", REQ_ACK, BAG_ACK);
        @(negedge clk);
        check("to_err_one_cycle", 32'(bus.err), 32'd0);
        wait_fs_rise("to_retry_fs", t_at);
        check("to_retry_delay", 32'(t_at - t_fall), 32'(GAP + 4));
        check("to_retry_btype", 32'(bus.btype), 32'(BAG_ACK));
        wait_drain("to_retry");
        err_allowed = 1'b0;
`endif

        repeat (5) @(negedge clk);
        check("final_scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end
endmodule
